// File: rtl/mem_port_arbiter.sv
// Two-requester round-robin arbiter and sequencer for the single data-memory port.
// A wait-cycle watchdog aborts accesses the memory never acknowledges and reports an error.
module mem_port_arbiter #(
    parameter int ADDR_W  = 8,
    parameter int DATA_W  = 8,
    parameter int TIMEOUT = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              p0_req,
    input  logic              p0_we,
    input  logic [ADDR_W-1:0] p0_addr,
    input  logic [DATA_W-1:0] p0_wdata,
    output logic              p0_gnt,
    output logic              p0_done,
    output logic              p0_err,
    output logic [DATA_W-1:0] p0_rdata,
    input  logic              p1_req,
    input  logic              p1_we,
    input  logic [ADDR_W-1:0] p1_addr,
    input  logic [DATA_W-1:0] p1_wdata,
    output logic              p1_gnt,
    output logic              p1_done,
    output logic              p1_err,
    output logic [DATA_W-1:0] p1_rdata,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_ready,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy
);
    typedef enum logic [1:0] {IDLE = 2'd0, ACCESS = 2'd1, DONE = 2'd2} state_t;

    // Counter value that, incremented once more without mem_ready, hits the watchdog limit.
    localparam logic [3:0] WAIT_LIMIT = 4'(TIMEOUT - 1);

    state_t            state, state_n;
    logic              owner, owner_n;
    logic              last_grant, last_grant_n;
    logic              win;
    logic [3:0]        wait_cnt, wait_cnt_n;
    logic              mem_req_n, mem_we_n;
    logic [ADDR_W-1:0] mem_addr_n;
    logic [DATA_W-1:0] mem_wdata_n;
    logic              p0_gnt_n, p1_gnt_n, p0_done_n, p1_done_n, p0_err_n, p1_err_n;
    logic [DATA_W-1:0] p0_rdata_n, p1_rdata_n;
    logic              busy_n;

    always_comb begin
        state_n      = state;
        owner_n      = owner;
        last_grant_n = last_grant;
        win          = 1'b0;
        wait_cnt_n   = wait_cnt;
        mem_req_n    = 1'b0;
        mem_we_n     = mem_we;
        mem_addr_n   = mem_addr;
        mem_wdata_n  = mem_wdata;
        p0_gnt_n     = 1'b0;
        p1_gnt_n     = 1'b0;
        p0_done_n    = 1'b0;
        p1_done_n    = 1'b0;
        p0_err_n     = 1'b0;
        p1_err_n     = 1'b0;
        p0_rdata_n   = p0_rdata;
        p1_rdata_n   = p1_rdata;
        busy_n       = 1'b0;

        case (state)
            IDLE: begin
                if (p0_req || p1_req) begin
                    // A tie goes to whichever port was not served last.
                    win          = (p0_req && p1_req) ? ~last_grant : p1_req;
                    owner_n      = win;
                    last_grant_n = win;
                    mem_we_n     = win ? p1_we    : p0_we;
                    mem_addr_n   = win ? p1_addr  : p0_addr;
                    mem_wdata_n  = win ? p1_wdata : p0_wdata;
                    p0_gnt_n     = ~win;
                    p1_gnt_n     = win;
                    mem_req_n    = 1'b1;
                    wait_cnt_n   = 4'd0;
                    busy_n       = 1'b1;
                    state_n      = ACCESS;
                end
            end
            ACCESS: begin
                busy_n = 1'b1;
                if (mem_ready) begin
                    state_n   = DONE;
                    p0_done_n = ~owner;
                    p1_done_n = owner;
                    if (!mem_we) begin
                        if (owner) p1_rdata_n = mem_rdata;
                        else       p0_rdata_n = mem_rdata;
                    end
                end else if (wait_cnt == WAIT_LIMIT) begin
                    state_n    = DONE;
                    wait_cnt_n = wait_cnt + 4'd1;
                    p0_done_n  = ~owner;
                    p1_done_n  = owner;
                    p0_err_n   = ~owner;
                    p1_err_n   = owner;
                end else begin
                    mem_req_n  = 1'b1;
                    wait_cnt_n = wait_cnt + 4'd1;
                end
            end
            DONE: begin
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            owner      <= 1'b0;
            last_grant <= 1'b1;
            wait_cnt   <= 4'd0;
            mem_req    <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            p0_gnt     <= 1'b0;
            p1_gnt     <= 1'b0;
            p0_done    <= 1'b0;
            p1_done    <= 1'b0;
            p0_err     <= 1'b0;
            p1_err     <= 1'b0;
            p0_rdata   <= '0;
            p1_rdata   <= '0;
            busy       <= 1'b0;
        end else begin
            state      <= state_n;
            owner      <= owner_n;
            last_grant <= last_grant_n;
            wait_cnt   <= wait_cnt_n;
            mem_req    <= mem_req_n;
            mem_we     <= mem_we_n;
            mem_addr   <= mem_addr_n;
            mem_wdata  <= mem_wdata_n;
            p0_gnt     <= p0_gnt_n;
            p1_gnt     <= p1_gnt_n;
            p0_done    <= p0_done_n;
            p1_done    <= p1_done_n;
            p0_err     <= p0_err_n;
            p1_err     <= p1_err_n;
            p0_rdata   <= p0_rdata_n;
            p1_rdata   <= p1_rdata_n;
            busy       <= busy_n;
        end
    end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: a vector table of single transactions, hand-written
// contention and reset sequences, and a scoreboard checked on every done pulse.
`timescale 1ns/1ps
module tb_mem_port_arbiter;
    localparam int ADDR_W  = 8;
    localparam int DATA_W  = 8;
    localparam int TIMEOUT = 8;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       p0_req = 1'b0, p0_we = 1'b0;
    logic [7:0] p0_addr = 8'h00, p0_wdata = 8'h00;
    logic       p0_gnt, p0_done, p0_err;
    logic [7:0] p0_rdata;
    logic       p1_req = 1'b0, p1_we = 1'b0;
    logic [7:0] p1_addr = 8'h00, p1_wdata = 8'h00;
    logic       p1_gnt, p1_done, p1_err;
    logic [7:0] p1_rdata;
    logic       mem_req, mem_we;
    logic [7:0] mem_addr, mem_wdata;
    logic       mem_ready = 1'b0;
    logic [7:0] mem_rdata = 8'h00;
    logic       busy;

    mem_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .reset(reset),
        .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
        .p0_gnt(p0_gnt), .p0_done(p0_done), .p0_err(p0_err), .p0_rdata(p0_rdata),
        .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
        .p1_gnt(p1_gnt), .p1_done(p1_done), .p1_err(p1_err), .p1_rdata(p1_rdata),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_ready(mem_ready), .mem_rdata(mem_rdata), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit         port;
        bit         we;
        logic [7:0] addr;
        logic [7:0] wdata;
        int         delay;
        logic [7:0] mdata;
        bit         exp_err;
        logic [7:0] exp_rdata;
        int         exp_lat;
    } vec_t;

    typedef struct {
        bit         port;
        bit         err;
        logic [7:0] rdata;
        int         lat;
    } exp_t;

    exp_t sb[$];
    vec_t vecs[9];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   gnt_cyc[2];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_ctrl"}, 32'({mem_req, mem_we, p0_gnt, p1_gnt, p0_done, p1_done,
                                 p0_err, p1_err, busy}), 32'd0);
        chk({tag, "_data"}, {mem_addr, mem_wdata, p0_rdata, p1_rdata}, 32'd0);
    endtask

    task automatic check_done(input bit p);
        exp_t e;
        if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_done: port %0d pulsed done, none expected", p);
        end else begin
            e = sb.pop_front();
            chk("done_port", 32'(p), 32'(e.port));
            chk("done_err", 32'(p ? p1_err : p0_err), 32'(e.err));
            chk("done_rdata", 32'(p ? p1_rdata : p0_rdata), 32'(e.rdata));
            chk("done_latency", cyc - gnt_cyc[p], e.lat);
        end
    endtask

    // Done-pulse monitor with protocol sanity checks.
    always @(negedge clk) begin
        if (!reset) begin
            if (p0_gnt) gnt_cyc[0] = cyc;
            if (p1_gnt) gnt_cyc[1] = cyc;
            if (p0_done) check_done(1'b0);
            if (p1_done) check_done(1'b1);
            if ((p0_err && !p0_done) || (p1_err && !p1_done)) begin
                errors++;
                $display("FAIL err_without_done: p0 err/done %b%b p1 err/done %b%b",
                         p0_err, p0_done, p1_err, p1_done);
            end
            if ((p0_gnt && p1_gnt) || (p0_done && p1_done)) begin
                errors++;
                $display("FAIL both_ports_active: gnt %b%b done %b%b, expected one owner",
                         p1_gnt, p0_gnt, p1_done, p0_done);
            end
        end
    end

    task automatic set_req(input bit p, input logic r, input logic we,
                           input logic [7:0] a, input logic [7:0] d);
        if (p) begin
            p1_req = r; p1_we = we; p1_addr = a; p1_wdata = d;
        end else begin
            p0_req = r; p0_we = we; p0_addr = a; p0_wdata = d;
        end
    endtask

    task automatic do_txn(input vec_t v, input int idx);
        int n;
        int k;
        bit seen;
        bit stable;
        bit fin;
        @(negedge clk);
        set_req(v.port, 1'b1, v.we, v.addr, v.wdata);
        sb.push_back('{v.port, v.exp_err, v.exp_rdata, v.exp_lat});
        seen = 1'b0;
        n = 0;
        while (!seen && n < 8) begin
            @(negedge clk);
            n++;
            seen = v.port ? p1_gnt : p0_gnt;
        end
        chk($sformatf("v%0d_gnt_latency", idx), n, 1);
        chk($sformatf("v%0d_gnt_mem_ctrl", idx), 32'({mem_req, mem_we, busy}),
            32'({1'b1, v.we, 1'b1}));
        chk($sformatf("v%0d_gnt_mem_addr", idx), 32'(mem_addr), 32'(v.addr));
        chk($sformatf("v%0d_gnt_mem_wdata", idx), 32'(mem_wdata), 32'(v.wdata));
        set_req(v.port, 1'b0, v.we, v.addr, v.wdata);
        stable = 1'b1;
        fin = 1'b0;
        k = 0;
        while (!fin && k < 40) begin
            mem_ready = (k == v.delay);
            mem_rdata = (k == v.delay) ? v.mdata : 8'($urandom);
            @(negedge clk);
            k++;
            fin = v.port ? p1_done : p0_done;
            if (!fin && (!mem_req || mem_we !== v.we || mem_addr !== v.addr ||
                         mem_wdata !== v.wdata))
                stable = 1'b0;
        end
        mem_ready = 1'b0;
        chk($sformatf("v%0d_done_seen", idx), 32'(fin), 32'd1);
        chk($sformatf("v%0d_access_stable", idx), 32'(stable), 32'd1);
        chk($sformatf("v%0d_done_mem_req", idx), 32'(mem_req), 32'd0);
        @(negedge clk);
        chk($sformatf("v%0d_idle_after_done", idx), 32'({busy, p0_done, p1_done}), 32'd0);
    endtask

    task automatic contention();
        logic [7:0] rr_data [4];
        bit seen;
        bit g;
        rr_data = '{8'h11, 8'h22, 8'h33, 8'h44};
        @(negedge clk);
        set_req(1'b0, 1'b1, 1'b0, 8'h50, 8'h00);
        set_req(1'b1, 1'b1, 1'b0, 8'h60, 8'h00);
        for (int i = 0; i < 4; i++) begin
            seen = 1'b0;
            for (int n = 0; n < 8 && !seen; n++) begin
                @(negedge clk);
                if (p0_gnt || p1_gnt) seen = 1'b1;
            end
            chk("rr_gnt_seen", 32'(seen), 32'd1);
            g = p1_gnt;
            chk("rr_order", 32'(g), 32'(i % 2));
            chk("rr_mem_addr", 32'(mem_addr), g ? 32'h60 : 32'h50);
            sb.push_back('{g, 1'b0, rr_data[i], 1});
            if (g) p1_req = 1'b0; else p0_req = 1'b0;
            if (i == 3) begin
                p0_req = 1'b0;
                p1_req = 1'b0;
            end
            mem_ready = 1'b1;
            mem_rdata = rr_data[i];
            @(negedge clk);
            mem_ready = 1'b0;
            chk("rr_done", 32'(g ? p1_done : p0_done), 32'd1);
            if (i < 3) begin
                if (g) p1_req = 1'b1; else p0_req = 1'b1;
            end
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic reset_mid_access();
        bit seen;
        @(negedge clk);
        set_req(1'b0, 1'b1, 1'b0, 8'h77, 8'h00);
        seen = 1'b0;
        for (int n = 0; n < 8 && !seen; n++) begin
            @(negedge clk);
            seen = p0_gnt;
        end
        chk("rma_gnt", 32'(seen), 32'd1);
        p0_req = 1'b0;
        mem_ready = 1'b0;
        repeat (3) @(negedge clk);
        chk("rma_in_access", 32'({mem_req, busy}), 32'd3);
        #2 reset = 1'b1;
        #1 check_zero("rma_reset");
        seen = 1'b0;
        repeat (2) begin
            @(negedge clk);
            if (p0_done || p1_done || mem_req || busy) seen = 1'b1;
        end
        chk("rma_quiet_in_reset", 32'(seen), 32'd0);
        reset = 1'b0;
        set_req(1'b0, 1'b1, 1'b0, 8'h81, 8'h00);
        set_req(1'b1, 1'b1, 1'b0, 8'h82, 8'h00);
        seen = 1'b0;
        for (int n = 0; n < 8 && !seen; n++) begin
            @(negedge clk);
            seen = p0_gnt || p1_gnt;
        end
        chk("rma_first_tie_p0", 32'({p1_gnt, p0_gnt}), 32'd1);
        sb.push_back('{1'b0, 1'b0, 8'h42, 1});
        p0_req = 1'b0;
        p1_req = 1'b0;
        mem_ready = 1'b1;
        mem_rdata = 8'h42;
        @(negedge clk);
        mem_ready = 1'b0;
        chk("rma_done", 32'(p0_done), 32'd1);
        @(negedge clk);
    endtask

    initial begin
        vecs[0] = '{1'b0, 1'b0, 8'h05, 8'h00, 0,   8'h3C, 1'b0, 8'h3C, 1};
        vecs[1] = '{1'b1, 1'b1, 8'h0A, 8'h7F, 3,   8'hEE, 1'b0, 8'h44, 4};
        vecs[2] = '{1'b0, 1'b0, 8'h10, 8'h00, 255, 8'hEE, 1'b1, 8'h3C, 8};
        vecs[3] = '{1'b1, 1'b0, 8'h20, 8'h00, 1,   8'h99, 1'b0, 8'h99, 2};
        vecs[4] = '{1'b0, 1'b0, 8'h30, 8'h00, 7,   8'hA5, 1'b0, 8'hA5, 8};
        vecs[5] = '{1'b1, 1'b0, 8'h40, 8'h00, 8,   8'h55, 1'b1, 8'h99, 8};
        vecs[6] = '{1'b0, 1'b1, 8'hFF, 8'h00, 2,   8'hEE, 1'b0, 8'hA5, 3};
        vecs[7] = '{1'b1, 1'b1, 8'h00, 8'hFF, 0,   8'hEE, 1'b0, 8'h99, 1};
        vecs[8] = '{1'b0, 1'b0, 8'hFF, 8'h00, 0,   8'h00, 1'b0, 8'h00, 1};

        repeat (2) @(negedge clk);
        check_zero("reset");
        reset = 1'b0;

        contention();
        for (int i = 0; i < 9; i++) do_txn(vecs[i], i);
        reset_mid_access();

        repeat (3) @(negedge clk);
        chk("scoreboard_drained", sb.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached before completion");
        $fatal(1, "time limit");
    end
endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Two-requester arbiter and sequencer for the single 8-bit data-memory port. Port 0 is the CPU load/store path; port 1 is the program loader / debug DMA. It accepts one request at a time with round-robin tie-breaking and drives the memory with a registered request/ready handshake. A wait-cycle watchdog aborts hung accesses and flags an error to the requester.

## Interface
- ADDR_W, 8, address width
- DATA_W, 8, data width
- TIMEOUT, 8, max ACCESS cycles without mem_ready before abort (1..15)

Ports:
- clk  in  1  clock; all logic on rising edge
- reset  in  1  reset, asynchronous, active-high
- pN_req  in  1  port N (N=0,1) request; held until pN_gnt seen
- pN_we  in  1  1=write, 0=read; valid with pN_req
- pN_addr  in  ADDR_W  access address; valid with pN_req
- pN_wdata  in  DATA_W  write data; valid with pN_req
- pN_gnt  out  1  one-cycle pulse: request accepted, payload captured
- pN_done  out  1  one-cycle pulse: access complete
- pN_err  out  1  high with pN_done when access timed out
- pN_rdata  out  DATA_W  read data; updated only on successful read completion, otherwise holds
- mem_req  out  1  memory access active
- mem_we  out  1  memory write strobe qualifier
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  DATA_W  memory write data
- mem_ready  in  1  memory completed current access (sampled only while mem_req=1)
- mem_rdata  in  DATA_W  read data, valid when mem_ready=1
- busy  out  1  state != IDLE

## Operation
- FSM: IDLE, ACCESS, DONE. All outputs are registered.
- IDLE: at a clock edge with any pN_req=1, pick the winner:
  - If only one port requests, that port wins.
  - If both request, the port not granted last wins (round-robin).
  - On the win: capture we/addr/wdata, set owner, update last_grant, and go to ACCESS. pN_gnt=1 for the owner, mem_req=1, wait counter = 0.
- ACCESS: mem_req/mem_we/mem_addr/mem_wdata are stable from the captured registers. pN_gnt is high only in the first ACCESS cycle.
  - Edge with mem_ready=1: go to DONE with err=0. On a read, capture mem_rdata into the owner's pN_rdata.
  - Edge with mem_ready=0: increment the counter. If the counter reaches TIMEOUT, go to DONE with err=1 and leave pN_rdata unchanged.
  - mem_ready=1 on the same edge the counter would reach TIMEOUT: ready wins, err=0.
- DONE: mem_req=0, owner pN_done=1, owner pN_err set as above. Go to IDLE on the next edge unconditionally; no arbitration happens in DONE.
- The non-owner's gnt, done and err stay 0 for the whole transaction.
- Requester rule: drop pN_req on the edge after seeing pN_gnt. A req still high in IDLE is a new request.
- Reset (asynchronous, any state):
  - state=IDLE.
  - All outputs 0: mem_req, mem_we, mem_addr, mem_wdata, pN_gnt, pN_done, pN_err, pN_rdata, busy.
  - Counter 0, last_grant=port 1, so port 0 wins the first tie.
  - An in-flight access is abandoned with no done pulse.

## Timing
- Edge E0 samples req in IDLE. mem_req and pN_gnt are high after E0.
- Earliest mem_ready is sampled at E1. pN_done/pN_rdata are valid after E1, and busy falls after E2.
- Minimum request-to-done latency is 2 cycles; minimum access period is 3 cycles (next sample at E3).
- Each wait cycle adds 1 cycle of latency.
- A timeout produces done/err after edge E0+TIMEOUT.
- With both ports requesting continuously, grants alternate 0,1,0,1.

## Test plan
- Single read: reset, p0 read addr 0x05, mem_ready=1 in first ACCESS cycle with mem_rdata=0x3C → p0_gnt at cycle 1, mem_addr=0x05, mem_we=0; p0_done at cycle 2 with p0_rdata=0x3C and p0_err=0.
- Write with waits: p1 write addr 0x0A data 0x7F, mem_ready delayed 3 cycles → mem_we=1, mem_wdata=0x7F stable 4 ACCESS cycles; p1_done after; p1_rdata unchanged.
- Contention: p0 and p1 both request at the same edge after reset, re-requesting after each done → grant order p0,p1,p0,p1; no overlap in mem_req ownership.
- Timeout: p0 read, mem_ready held 0, TIMEOUT=8 → p0_done with p0_err=1 exactly 8 cycles after gnt; p0_rdata retains its prior value; the FSM then serves p1.
- Ready at limit: mem_ready=1 on the TIMEOUT-th ACCESS cycle with mem_rdata=0xA5 → err=0, rdata=0xA5.
- Reset mid-access: assert reset during ACCESS with mem_ready=0 → mem_req, busy and all pN_* outputs drop immediately with no done pulse; after release, a simultaneous request goes to p0 first.
